// File: rtl/ibex_ex_wb_buffer.sv
// Writeback buffer between EX and the register-file write port: in-order FIFO of EX results
// with a valid/ready drain and combinational forwarding of pending results to ID operands.
module ibex_ex_wb_buffer #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned PtrW     = $clog2(Depth),
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic                 ex_rf_we_i,
  input  logic [4:0]           ex_rf_waddr_i,
  input  logic [DataWidth-1:0] ex_result_i,
  input  logic                 flush_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           fwd_raddr_a_i,
  input  logic [4:0]           fwd_raddr_b_i,
  output logic                 fwd_hit_a_o,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_rdata_a_o,
  output logic [DataWidth-1:0] fwd_rdata_b_o,
  output logic [CntW-1:0]      occupancy_o
);

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [4:0]           addr_q [Depth];
  logic [DataWidth-1:0] data_q [Depth];

  logic push, pop;
  logic [PtrW-1:0] fwd_idx;

  // Ready depends on registered count only, never on wb_ready_i.
  assign ex_ready_o = (count_q < CntW'(Depth)) & ~rst_i;
  assign wb_valid_o = (count_q != '0);
  assign pop        = wb_valid_o & wb_ready_i;
  // Accepted results without a real destination are dropped without allocating an entry.
  assign push       = ex_valid_i & ex_ready_o & ex_rf_we_i & (ex_rf_waddr_i != 5'd0) & ~flush_i;

  assign rf_waddr_o  = wb_valid_o ? addr_q[rd_ptr_q] : 5'd0;
  assign rf_wdata_o  = wb_valid_o ? data_q[rd_ptr_q] : '0;
  assign occupancy_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q] <= ex_rf_waddr_i;
      data_q[wr_ptr_q] <= ex_result_i;
    end
  end

  // Walk entries oldest to youngest so the last match is the youngest one.
  always_comb begin
    fwd_hit_a_o   = 1'b0;
    fwd_hit_b_o   = 1'b0;
    fwd_rdata_a_o = '0;
    fwd_rdata_b_o = '0;
    fwd_idx       = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      fwd_idx = rd_ptr_q + PtrW'(k);
      if (CntW'(k) < count_q) begin
        if ((fwd_raddr_a_i != 5'd0) && (addr_q[fwd_idx] == fwd_raddr_a_i)) begin
          fwd_hit_a_o   = 1'b1;
          fwd_rdata_a_o = data_q[fwd_idx];
        end
        if ((fwd_raddr_b_i != 5'd0) && (addr_q[fwd_idx] == fwd_raddr_b_i)) begin
          fwd_hit_b_o   = 1'b1;
          fwd_rdata_b_o = data_q[fwd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_ex_wb_buffer.sv
// Self-checking bench for ibex_ex_wb_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the buffer.
module tb_ibex_ex_wb_buffer;
  localparam int Depth = 2;
  localparam int DW    = 32;
  localparam int CW    = $clog2(Depth + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ex_valid_i = 1'b0;
  logic          ex_ready_o;
  logic          ex_rf_we_i = 1'b0;
  logic [4:0]    ex_rf_waddr_i = 5'd0;
  logic [DW-1:0] ex_result_i = '0;
  logic          flush_i = 1'b0;
  logic          wb_valid_o;
  logic          wb_ready_i = 1'b0;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [4:0]    fwd_raddr_a_i = 5'd0;
  logic [4:0]    fwd_raddr_b_i = 5'd0;
  logic          fwd_hit_a_o, fwd_hit_b_o;
  logic [DW-1:0] fwd_rdata_a_o, fwd_rdata_b_o;
  logic [CW-1:0] occupancy_o;

  always #5 clk_i = ~clk_i;

  ibex_ex_wb_buffer #(.Depth(Depth), .DataWidth(DW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_rf_we_i    (ex_rf_we_i),
    .ex_rf_waddr_i (ex_rf_waddr_i),
    .ex_result_i   (ex_result_i),
    .flush_i       (flush_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .fwd_raddr_a_i (fwd_raddr_a_i),
    .fwd_raddr_b_i (fwd_raddr_b_i),
    .fwd_hit_a_o   (fwd_hit_a_o),
    .fwd_hit_b_o   (fwd_hit_b_o),
    .fwd_rdata_a_o (fwd_rdata_a_o),
    .fwd_rdata_b_o (fwd_rdata_b_o),
    .occupancy_o   (occupancy_o)
  );

  typedef struct packed {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   errors = 0;
  int   checks = 0;
  bit   model_ok = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void fwd_ref(input logic [4:0] ra, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == ra) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
      end
    end
  endfunction

  task automatic check_model();
    logic          hit;
    logic [DW-1:0] d;
    chk("ex_ready", 32'(ex_ready_o), 32'(!rst_i && (mq.size() < Depth)));
    chk("wb_valid", 32'(wb_valid_o), 32'(mq.size() != 0));
    chk("rf_waddr", 32'(rf_waddr_o), (mq.size() != 0) ? 32'(mq[0].a) : 32'd0);
    chk("rf_wdata", rf_wdata_o, (mq.size() != 0) ? mq[0].d : 32'd0);
    chk("occupancy", 32'(occupancy_o), 32'(mq.size()));
    fwd_ref(fwd_raddr_a_i, hit, d);
    chk("fwd_hit_a", 32'(fwd_hit_a_o), 32'(hit));
    chk("fwd_rdata_a", fwd_rdata_a_o, d);
    fwd_ref(fwd_raddr_b_i, hit, d);
    chk("fwd_hit_b", 32'(fwd_hit_b_o), 32'(hit));
    chk("fwd_rdata_b", fwd_rdata_b_o, d);
  endtask

  task automatic update_model();
    bit do_pop, do_push;
    if (rst_i) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && wb_ready_i;
      do_push = ex_valid_i && (mq.size() < Depth) && ex_rf_we_i && (ex_rf_waddr_i != 5'd0);
      if (flush_i) begin
        mq.delete();
      end else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back('{a: ex_rf_waddr_i, d: ex_result_i});
      end
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are checked before the next one.
  task automatic step();
    #1;
    if (model_ok) check_model();
    @(posedge clk_i);
    update_model();
    model_ok = 1'b1;
    #1;
  endtask

  task automatic drv(input logic ev, input logic we, input logic [4:0] wa,
                     input logic [DW-1:0] res, input logic fl, input logic wr);
    ex_valid_i    = ev;
    ex_rf_we_i    = we;
    ex_rf_waddr_i = wa;
    ex_result_i   = res;
    flush_i       = fl;
    wb_ready_i    = wr;
  endtask

  initial begin
    // Initial reset
    rst_i = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_i = 1'b0;
    step();

    // Single push held by backpressure, then retired
    drv(1, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("push_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("push_waddr", 32'(rf_waddr_o), 32'd5);
    chk("push_wdata", rf_wdata_o, 32'hDEADBEEF);
    step();
    step();
    drv(0, 0, 0, 0, 0, 1);
    step();
    #1;
    chk("retired_occ", 32'(occupancy_o), 32'd0);

    // Fill, full backpressure, then pop with concurrent push
    drv(1, 1, 5'd1, 32'h1111, 0, 0);
    step();
    drv(1, 1, 5'd2, 32'h2222, 0, 0);
    step();
    drv(1, 1, 5'd3, 32'h3333, 0, 1);
    #1;
    chk("full_ready", 32'(ex_ready_o), 32'd0);
    chk("full_occ", 32'(occupancy_o), 32'd2);
    chk("full_head", 32'(rf_waddr_o), 32'd1);
    step();
    step();
    #1;
    chk("pop_push_occ", 32'(occupancy_o), 32'd1);
    chk("order_head", 32'(rf_waddr_o), 32'd3);
    drv(0, 0, 0, 0, 0, 1);
    step();

    // Mid-stream reset with two entries held
    drv(1, 1, 5'd4, 32'h4444, 0, 0);
    step();
    drv(1, 1, 5'd6, 32'h6666, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    chk("rst_ready", 32'(ex_ready_o), 32'd1);
    step();

    // Forwarding picks the youngest matching entry
    drv(1, 1, 5'd7, 32'd1, 0, 0);
    step();
    drv(1, 1, 5'd7, 32'd2, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    fwd_raddr_a_i = 5'd7;
    fwd_raddr_b_i = 5'd0;
    #1;
    chk("fwd_young_hit", 32'(fwd_hit_a_o), 32'd1);
    chk("fwd_young_data", fwd_rdata_a_o, 32'd2);
    chk("fwd_x0_nohit", 32'(fwd_hit_b_o), 32'd0);
    step();
    drv(0, 0, 0, 0, 0, 1);
    step();
    step();

    // Accepted but dropped results
    drv(1, 1, 5'd0, 32'hAAAA, 0, 0);
    step();
    drv(1, 0, 5'd9, 32'hBBBB, 0, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("drop_occ", 32'(occupancy_o), 32'd0);
    chk("drop_wb_valid", 32'(wb_valid_o), 32'd0);
    step();

    // Flush with two entries while popping and offering a push
    drv(1, 1, 5'd10, 32'hA0A0, 0, 0);
    step();
    drv(1, 1, 5'd11, 32'hB1B1, 0, 0);
    step();
    drv(1, 1, 5'd12, 32'hC2C2, 1, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("flush_occ", 32'(occupancy_o), 32'd0);
    chk("flush_wb_valid", 32'(wb_valid_o), 32'd0);
    step();

    // Flush with one entry and a push that would otherwise be accepted
    drv(1, 1, 5'd13, 32'hD3D3, 0, 0);
    step();
    drv(1, 1, 5'd14, 32'hE4E4, 1, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk("flush_push_occ", 32'(occupancy_o), 32'd0);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_i = ($urandom_range(0, 59) == 0);
      drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) != 0),
          5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 2) == 0));
      fwd_raddr_a_i = 5'($urandom_range(0, 7));
      fwd_raddr_b_i = 5'($urandom_range(0, 7));
      step();
    end
    rst_i = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
